// File: rtl/mac_pe_stream.sv
// mac_pe_stream: streaming multiply-accumulate processing element.
// Accepts operand beats, accumulates a dot product, forwards operands
// systolically, and hands the finished result to a one-deep output slot.
// Optional feature macro: MAC_PE_SAT_EN -- saturating accumulation with a
// sticky per-dot-product overflow flag. Undefined: acc wraps, psum_ovf = 0.
module mac_pe_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid,
  output logic              out_last,
  output logic [ACC_W-1:0]  psum,
  output logic [CNT_W-1:0]  psum_cnt,
  output logic              psum_ovf,
  output logic              psum_valid,
  input  logic              psum_ready
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_STALL} state_t;

  state_t r_state, w_state_nxt;

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic [DATA_W-1:0] r_out_a, r_out_b;
  logic              r_out_valid, r_out_last;
  logic [ACC_W-1:0]  r_psum;
  logic [CNT_W-1:0]  r_psum_cnt;
  logic              r_psum_ovf, r_psum_valid;

  logic              w_accept;
  logic [PW-1:0]     w_a_ext, w_b_ext, w_prod;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_sum;
  logic              w_ovf_add;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_acc_add, w_acc_clr, w_load_final, w_load_stall;

  // STALL is the only state that holds off new beats
  assign in_ready = (r_state != ST_STALL);
  assign w_accept = in_valid && in_ready;

  // Extending operands to 2*DATA_W first makes the low 2*DATA_W product
  // bits correct for both signed and unsigned interpretation.
  assign w_a_ext    = (SIGNED != 0) ? PW'($signed(in_a)) : PW'(in_a);
  assign w_b_ext    = (SIGNED != 0) ? PW'($signed(in_b)) : PW'(in_b);
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = (SIGNED != 0) ? ACC_W'($signed(w_prod)) : ACC_W'(w_prod);

  assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef MAC_PE_SAT_EN
  logic [ACC_W:0] w_sum_raw;
  // Saturating add: clamp to the representable range and flag the overflow
  always_comb begin
    w_sum_raw = {1'b0, r_acc} + {1'b0, w_prod_ext};
    w_sum     = w_sum_raw[ACC_W-1:0];
    w_ovf_add = 1'b0;
    if (SIGNED != 0) begin
      if ((r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
          (w_sum_raw[ACC_W-1] != r_acc[ACC_W-1])) begin
        w_ovf_add = 1'b1;
        w_sum     = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (w_sum_raw[ACC_W]) begin
      w_ovf_add = 1'b1;
      w_sum     = '1;
    end
  end
`else
  assign w_sum     = r_acc + w_prod_ext;
  assign w_ovf_add = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and datapath control
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_add    = 1'b0;
    w_acc_clr    = 1'b0;
    w_load_final = 1'b0;
    w_load_stall = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACC: begin
        if (w_accept) begin
          if (!in_last) begin
            w_state_nxt = ST_ACC;
            w_acc_add   = 1'b1;
          end else if (!r_psum_valid || psum_ready) begin
            // slot free or being emptied this edge: result goes straight out
            w_state_nxt  = ST_IDLE;
            w_load_final = 1'b1;
            w_acc_clr    = 1'b1;
          end else begin
            // slot busy: park the finished result in acc
            w_state_nxt = ST_STALL;
            w_acc_add   = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (psum_ready) begin
          w_state_nxt  = ST_IDLE;
          w_load_stall = 1'b1;
          w_acc_clr    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accumulator, term counter and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_acc_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_acc_add) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_nxt;
      r_ovf <= r_ovf | w_ovf_add;
    end
  end

  // Result slot: reload wins over the consumer's take on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psum       <= '0;
      r_psum_cnt   <= '0;
      r_psum_ovf   <= 1'b0;
      r_psum_valid <= 1'b0;
    end else if (w_load_final) begin
      r_psum       <= w_sum;
      r_psum_cnt   <= w_cnt_nxt;
      r_psum_ovf   <= r_ovf | w_ovf_add;
      r_psum_valid <= 1'b1;
    end else if (w_load_stall) begin
      r_psum       <= r_acc;
      r_psum_cnt   <= r_cnt;
      r_psum_ovf   <= r_ovf;
      r_psum_valid <= 1'b1;
    end else if (r_psum_valid && psum_ready) begin
      r_psum_valid <= 1'b0;
    end
  end

  // Systolic forwards, one cycle behind the input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_a     <= in_a;
      r_out_b     <= in_b;
      r_out_valid <= w_accept;
      r_out_last  <= w_accept && in_last;
    end
  end

  assign out_a      = r_out_a;
  assign out_b      = r_out_b;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign psum       = r_psum;
  assign psum_cnt   = r_psum_cnt;
  assign psum_ovf   = r_psum_ovf;
  assign psum_valid = r_psum_valid;

endmodule

// File: doc/mac_pe_stream.md
MAC_PE_STREAM -- requirements
Module: mac_pe_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 32, accumulator/result width; legal only if ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter CNT_W, default 8, term-counter width.
REQ-004 SHALL have parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, operand beat present.
REQ-008 SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready.
REQ-009 SHALL have ports in_a and in_b, input, DATA_W each, operands.
REQ-010 SHALL have port in_last, input, 1, marks the final term of a dot product.
REQ-011 SHALL have ports out_a and out_b, output, DATA_W each, registered systolic forwards of in_a and in_b.
REQ-012 SHALL have ports out_valid and out_last, output, 1 each, registered forwards of the accepted beat.
REQ-013 SHALL have port psum, output, ACC_W, completed dot-product result.
REQ-014 SHALL have port psum_cnt, output, CNT_W, number of terms in psum.
REQ-015 SHALL have port psum_ovf, output, 1, overflow occurred in psum.
REQ-016 SHALL have port psum_valid, output, 1, result slot occupied.
REQ-017 SHALL have port psum_ready, input, 1, consumer takes result when psum_valid && psum_ready.

Function
REQ-018 SHALL accept a beat when in_valid && in_ready; non-accepted cycles leave acc and counter unchanged.
REQ-019 SHALL compute the product at full 2*DATA_W width, sign- or zero-extend it per SIGNED to ACC_W, and add it to acc.
REQ-020 SHALL forward each cycle: out_a<=in_a, out_b<=in_b, out_valid<=in_valid&&in_ready, out_last<=in_last&&in_valid&&in_ready (one-cycle latency).
REQ-021 SHALL count accepted terms in cnt, saturating at 2^CNT_W-1.
REQ-022 SHALL implement states IDLE (acc=0, cnt=0), ACC (partial sum held), STALL (finished result held in acc, slot busy).
REQ-023 SHALL drive in_ready = 1 in IDLE and ACC, 0 in STALL.
REQ-024 SHALL move IDLE->ACC, or stay in ACC, on an accepted beat with in_last=0.
REQ-025 SHALL, on an accepted beat with in_last=1: if slot is free or freeing (!psum_valid || psum_ready), load psum/psum_cnt/psum_ovf with final values, set psum_valid, clear acc/cnt/ovf and enter IDLE; otherwise keep the final values in acc and enter STALL.
REQ-026 SHALL, in STALL, when psum_ready=1, load the slot from acc, clear acc/cnt/ovf and enter IDLE in the same edge.
REQ-027 SHALL clear psum_valid on psum_valid && psum_ready unless reloaded that same edge, in which case psum_valid stays 1.
REQ-028 SHALL give a result latency of one cycle: psum_valid high the cycle after the accepted last beat when the slot is free.
REQ-029 SHALL treat a single-beat dot product (in_last on the first term) as cnt=1.

Reset
REQ-030 SHALL, while rst=0, asynchronously force state=IDLE, acc=0, cnt=0, and all outputs to 0 except in_ready=1 once idle; in-flight dot products are discarded.
REQ-031 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-032 SHALL honour macro MAC_PE_SAT_EN: when defined, each addition saturates to the ACC_W range (signed or unsigned per SIGNED) and sets a per-dot-product sticky ovf that is copied to psum_ovf.
REQ-033 SHALL, without MAC_PE_SAT_EN, wrap acc modulo 2^ACC_W and tie psum_ovf to 0.

Verification
REQ-034 SHALL cover: SIGNED=1, DATA_W=8; beats (3,4),(-2,5),(7,-1,last), psum_ready=1 -> psum=-5, psum_cnt=3, psum_valid one cycle after last.
REQ-035 SHALL cover: psum_ready=0 with slot full, second last beat -> in_ready=0 (STALL); raise psum_ready -> first result taken, second loaded next edge, in_ready=1.
REQ-036 SHALL cover: ACC_W=16, 3 beats of (127,127) -> with MAC_PE_SAT_EN, psum=32767 and psum_ovf=1; without it, psum=-17149 (wrapped) and psum_ovf=0.
REQ-037 SHALL cover: rst=0 pulse mid-dot-product, outside clk edge -> outputs 0 immediately; new dot product (2,2,last) -> psum=4, cnt=1.
REQ-038 SHALL cover: in_valid toggling with stalls -> out_a/out_b/out_valid match accepted inputs delayed one cycle; no forward while in_ready=0.
REQ-039 SHALL cover: SIGNED=0, (255,255,last) -> psum=65025.
